// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//
// Purpose:
//    Holds the 32-bit program counter of a simple RISC-style core and picks
//    the next instruction address every clock. The next address is one of:
//    the reset vector, an absolute register-indirect target (jalr), a
//    PC-relative target (pc + signed immediate) or the sequential address
//    (pc + 4). All arithmetic wraps modulo 2^32 and no alignment checking is
//    done; targets and offsets pass through exactly as supplied.
//
// Parameters:
//    RESET_VECTOR  value loaded into pc while reset is asserted
//
// Ports:
//    clk          in   1   single clock, all state changes on its rising edge
//    reset        in   1   synchronous active-low reset (0 = asserted)
//    pc_src       in   1   1 = PC-relative branch/jump taken this cycle
//    jalr         in   1   1 = absolute register-indirect jump taken
//    immediate    in   32  signed offset added to pc when pc_src = 1
//    jump_target  in   32  absolute next pc when jalr = 1
//    pc           out  32  current program counter, straight from a register
// -----------------------------------------------------------------------------
module program_counter #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_src,
   input  logic        jalr,
   input  logic [31:0] immediate,
   input  logic [31:0] jump_target,
   output logic [31:0] pc
);

   logic [31:0] pc_reg;
   logic [31:0] next_pc;

   // Next-address selection for the non-reset case. jalr outranks pc_src so
   // that a register-indirect jump wins if the decoder ever raises both.
   // The immediate is two's-complement, so a plain 32-bit add already moves
   // backwards for negative offsets and wraps silently on overflow.
   always_comb begin
      next_pc = pc_reg + 32'd4;
      if (jalr) begin
         next_pc = jump_target;
      end else if (pc_src) begin
         next_pc = pc_reg + immediate;
      end
   end

   // The pc register itself. Reset is sampled only at the clock edge, so
   // pulling reset low between edges leaves pc alone until the next edge,
   // and reset overrides any jump requested in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg <= RESET_VECTOR;
      end else begin
         pc_reg <= next_pc;
      end
   end

   // The output is the register itself, so there is no combinational path
   // from any input to pc.
   assign pc = pc_reg;

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//
// Purpose:
//    Directed self-checking bench for program_counter. A default instance
//    (RESET_VECTOR = 0) carries most checks; a second instance with a
//    non-zero reset vector shares the same inputs so the parameter is
//    exercised as well. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_program_counter;

   logic        clk;
   logic        reset;
   logic        pc_src;
   logic        jalr;
   logic [31:0] immediate;
   logic [31:0] jump_target;
   logic [31:0] pc;
   logic [31:0] pc_rv;

   int vectorCount;
   int failCount;

   program_counter dut (
      .clk         (clk),
      .reset       (reset),
      .pc_src      (pc_src),
      .jalr        (jalr),
      .immediate   (immediate),
      .jump_target (jump_target),
      .pc          (pc)
   );

   program_counter #(.RESET_VECTOR(32'h8000_0000)) dut_rv (
      .clk         (clk),
      .reset       (reset),
      .pc_src      (pc_src),
      .jalr        (jalr),
      .immediate   (immediate),
      .jump_target (jump_target),
      .pc          (pc_rv)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one set of inputs, lets one rising edge take them, then settles
   // 1 time unit past the edge so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic rst, input logic j, input logic src,
                                input logic [31:0] imm, input logic [31:0] tgt);
      reset       = rst;
      jalr        = j;
      pc_src      = src;
      immediate   = imm;
      jump_target = tgt;
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, and on a miss counts the failure and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // The whole directed sequence, one step per edge unless noted.
   initial begin
      vectorCount = 0;
      failCount   = 0;
      reset       = 1'b0;
      jalr        = 1'b0;
      pc_src      = 1'b0;
      immediate   = 32'h0;
      jump_target = 32'h0;
      @(negedge clk);

      // Reset then straight-line fetch.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("reset_pc", pc, 32'h0000_0000);
      checkOutput("reset_vector_param", pc_rv, 32'h8000_0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("seq_4", pc, 32'd4);
      checkOutput("seq_param_4", pc_rv, 32'h8000_0004);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("seq_8", pc, 32'd8);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("seq_12", pc, 32'd12);

      // PC-relative branch forward, then sequential.
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd20, 32'h0);
      checkOutput("branch_32", pc, 32'd32);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd20, 32'h0);
      checkOutput("seq_36", pc, 32'd36);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd20, 32'h0);
      checkOutput("seq_40", pc, 32'd40);

      // Absolute jump, then sequential.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'd100);
      checkOutput("jalr_100", pc, 32'd100);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'd100);
      checkOutput("seq_104", pc, 32'd104);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'd100);
      checkOutput("seq_108", pc, 32'd108);

      // jalr beats pc_src; negative offset moves backwards.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd8, 32'd200);
      checkOutput("jalr_priority_200", pc, 32'd200);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'd200);
      checkOutput("branch_back_192", pc, 32'd192);

      // Sequential wrap at the top of the address space.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
      checkOutput("jalr_top", pc, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("seq_wrap_0", pc, 32'h0000_0000);

      // Relative-add overflow wraps silently.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF0);
      checkOutput("jalr_fff0", pc, 32'hFFFF_FFF0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
      checkOutput("branch_wrap_10", pc, 32'h0000_0010);

      // Misaligned target and offset pass through unchanged.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_1003);
      checkOutput("jalr_misaligned", pc, 32'h0000_1003);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'h0);
      checkOutput("branch_odd", pc, 32'h0000_1004);

      // Reset overrides a simultaneous jalr and pc_src.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'd8, 32'd100);
      checkOutput("reset_over_jump", pc, 32'h0000_0000);
      checkOutput("reset_over_jump_param", pc_rv, 32'h8000_0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("post_reset_4", pc, 32'd4);

      // A jump raised and dropped between edges has no effect.
      #1;
      jalr        = 1'b1;
      jump_target = 32'd500;
      #1;
      checkOutput("no_comb_path", pc, 32'd4);
      jalr        = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("glitch_ignored_8", pc, 32'd8);

      // Reset dropped between edges only acts at the next edge.
      #1;
      reset = 1'b0;
      #1;
      checkOutput("reset_mid_cycle_hold", pc, 32'd8);
      @(posedge clk);
      #1;
      checkOutput("reset_mid_cycle_edge", pc, 32'h0000_0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("release_4", pc, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, the value loaded into pc while reset is asserted.
REQ-002 Port: clk, input, 1, the single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port: reset, input, 1, synchronous active-low reset (0 = reset asserted).
REQ-004 Port: pc_src, input, 1, 1 = PC-relative branch/jump taken this cycle.
REQ-005 Port: jalr, input, 1, 1 = absolute register-indirect jump taken this cycle.
REQ-006 Port: immediate, input, 32, signed two's-complement offset added to pc when pc_src=1.
REQ-007 Port: jump_target, input, 32, absolute next-PC value used when jalr=1.
REQ-008 Port: pc, output, 32, current program counter, driven directly from a register.

Function
REQ-009 pc SHALL be a 32-bit register updated only on the rising edge of clk.
REQ-010 Next-pc selection SHALL use this priority: reset asserted, then jalr, then pc_src, then sequential.
REQ-011 When reset=0 at a rising edge, pc SHALL become RESET_VECTOR, regardless of jalr, pc_src, immediate and jump_target.
REQ-012 When reset=1 and jalr=1, pc SHALL become jump_target verbatim, with no bit masking; the caller supplies an already-formed target.
REQ-013 When reset=1, jalr=0 and pc_src=1, pc SHALL become pc + immediate, modulo 2^32; immediate is treated as signed, so negative offsets move backwards.
REQ-014 When reset=1, jalr=0 and pc_src=0, pc SHALL become pc + 4, modulo 2^32.
REQ-015 When jalr=1 and pc_src=1 in the same cycle, jalr SHALL win.
REQ-016 Latency: a selection made at edge N SHALL be visible on pc immediately after edge N; there SHALL be no combinational path from any input to pc.
REQ-017 Wrap-around: 32'hFFFF_FFFC + 4 SHALL give 32'h0000_0000, and overflow on pc + immediate SHALL wrap silently; no flag is produced.
REQ-018 The block SHALL perform no alignment checking; misaligned targets and offsets SHALL pass through unchanged.
REQ-019 Inputs SHALL be sampled only at the rising edge; changes between edges SHALL have no effect on pc.

Reset
REQ-020 Reset SHALL be synchronous: asserting reset between edges SHALL NOT change pc until the next rising edge.
REQ-021 Reset asserted mid-operation, including during jalr=1 or pc_src=1, SHALL load RESET_VECTOR at that edge.
REQ-022 On the first rising edge after reset returns to 1, pc SHALL advance normally from RESET_VECTOR, e.g. to RESET_VECTOR+4 when no jump is requested.
REQ-023 Before the first reset edge, the pc value is undefined; benches SHALL apply reset before checking pc.

Verification
REQ-024 reset=0 for 1 cycle, then reset=1 with jalr=0 and pc_src=0 -> pc=0 after the reset edge, then 4, 8, 12 on the next three edges.
REQ-025 From pc=12, pc_src=1 and immediate=20 for 1 edge -> pc=32; then pc_src=0 for 2 edges -> pc=36, then 40.
REQ-026 From pc=40, jalr=1 and jump_target=100 for 1 edge -> pc=100; then jalr=0 for 2 edges -> pc=104, then 108.
REQ-027 jalr=1, pc_src=1, immediate=8, jump_target=200 -> pc=200; immediate=32'hFFFF_FFF8 (-8) from pc=200 with pc_src=1 -> pc=192.
REQ-028 From pc=32'hFFFF_FFFC with no jump -> pc=0; reset=0 asserted together with jalr=1 and jump_target=100 -> pc=0.
REQ-029 Drive reset=0 only between edges -> pc is unchanged until the following rising edge, then equals 0.
